// File: rtl/uart_num_parser.sv
// Receive-side ASCII decimal tokenizer: whitespace-delimited numbers in, one value or error pulse per token out.
// Optional signed tokens ("-12") are enabled by defining UART_NUM_NEG_EN.
module uart_num_parser #(
  parameter int VAL_W      = 8,
  parameter int MAX_VAL    = 255,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             flush,
  output logic             num_valid,
  output logic [VAL_W-1:0] num_value,
  output logic             num_err,
  output logic             busy
);

  localparam int PW = VAL_W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);

`ifdef UART_NUM_NEG_EN
  localparam int HALF    = 2 ** (VAL_W - 1);
  localparam int POS_LIM = (MAX_VAL < HALF - 1) ? MAX_VAL : HALF - 1;
  localparam int NEG_LIM = (MAX_VAL < HALF) ? MAX_VAL : HALF;
`else
  localparam int POS_LIM = MAX_VAL;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_NUM,
    S_SKIP
`ifdef UART_NUM_NEG_EN
    , S_SIGN
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [VAL_W-1:0] num_value_q, num_value_d;
  logic             num_valid_q, num_valid_d;
  logic             num_err_q, num_err_d;
  logic             tok_clear;

  logic             is_digit, is_delim;
  logic [3:0]       digit;
  logic [PW-1:0]    digit_w, prod, lim;
  logic [VAL_W-1:0] signed_acc;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign digit    = rx_data[3:0];
  assign digit_w  = PW'(digit);
  // acc never exceeds the limit, so acc*10+9 always fits in VAL_W+4 bits
  assign prod     = PW'(acc_q) * PW'(10) + digit_w;

`ifdef UART_NUM_NEG_EN
  logic neg_q, neg_d;
  logic is_minus;
  assign is_minus   = (rx_data == 8'h2D);
  assign lim        = neg_q ? PW'(NEG_LIM) : PW'(POS_LIM);
  assign signed_acc = neg_q ? (VAL_W'(0) - acc_q) : acc_q;
`else
  assign lim        = PW'(POS_LIM);
  assign signed_acc = acc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      num_value_q <= '0;
      num_valid_q <= 1'b0;
      num_err_q   <= 1'b0;
`ifdef UART_NUM_NEG_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      num_value_q <= num_value_d;
      num_valid_q <= num_valid_d;
      num_err_q   <= num_err_d;
`ifdef UART_NUM_NEG_EN
      neg_q       <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    num_value_d = num_value_q;
    num_valid_d = 1'b0;
    num_err_d   = 1'b0;
    tok_clear   = 1'b0;
`ifdef UART_NUM_NEG_EN
    neg_d       = neg_q;
`endif

    if (flush) begin
      state_d   = S_IDLE;
      tok_clear = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            state_d = S_NUM;
            acc_d   = VAL_W'(digit);
            cnt_d   = CW'(1);
            ovf_d   = digit_w > PW'(POS_LIM);
`ifdef UART_NUM_NEG_EN
          end else if (is_minus) begin
            state_d = S_SIGN;
`endif
          end else if (!is_delim) begin
            state_d = S_SKIP;
          end
        end

`ifdef UART_NUM_NEG_EN
        S_SIGN: begin
          if (is_digit) begin
            state_d = S_NUM;
            neg_d   = 1'b1;
            acc_d   = VAL_W'(digit);
            cnt_d   = CW'(1);
            ovf_d   = digit_w > PW'(NEG_LIM);
          end else if (is_delim) begin
            state_d   = S_IDLE;
            num_err_d = 1'b1;
            tok_clear = 1'b1;
          end else begin
            state_d = S_SKIP;
          end
        end
`endif

        S_NUM: begin
          if (is_digit) begin
            // once overflowed, acc and cnt freeze; the token is already lost
            if (!ovf_q) begin
              if ((prod > lim) || (cnt_q >= CW'(MAX_DIGITS))) begin
                ovf_d = 1'b1;
              end else begin
                acc_d = prod[VAL_W-1:0];
                cnt_d = cnt_q + CW'(1);
              end
            end
          end else if (is_delim) begin
            state_d   = S_IDLE;
            tok_clear = 1'b1;
            if (ovf_q) begin
              num_err_d = 1'b1;
            end else begin
              num_valid_d = 1'b1;
              num_value_d = signed_acc;
            end
          end else begin
            state_d = S_SKIP;
          end
        end

        S_SKIP: begin
          if (is_delim) begin
            state_d   = S_IDLE;
            num_err_d = 1'b1;
            tok_clear = 1'b1;
          end
        end

        default: begin
          state_d   = S_IDLE;
          tok_clear = 1'b1;
        end
      endcase
    end

    if (tok_clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
`ifdef UART_NUM_NEG_EN
      neg_d = 1'b0;
`endif
    end
  end

  assign num_valid = num_valid_q;
  assign num_err   = num_err_q;
  assign num_value = num_value_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_num_parser.sv
// Bench for uart_num_parser: token-level reference model checked every cycle, plus directed literal checks.
// Follows UART_NUM_NEG_EN the same way the design does.
module tb_uart_num_parser;

  localparam int VAL_W      = 8;
  localparam int MAX_VAL    = 255;
  localparam int MAX_DIGITS = 5;
  localparam int BAD        = 1 << 30;

`ifdef UART_NUM_NEG_EN
  localparam int POS_LIM = (MAX_VAL < 2 ** (VAL_W - 1) - 1) ? MAX_VAL : 2 ** (VAL_W - 1) - 1;
  localparam int NEG_LIM = (MAX_VAL < 2 ** (VAL_W - 1)) ? MAX_VAL : 2 ** (VAL_W - 1);
`else
  localparam int POS_LIM = MAX_VAL;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             flush = 1'b0;
  logic             num_valid, num_err, busy;
  logic [VAL_W-1:0] num_value;

  always #5 clk = ~clk;

  uart_num_parser #(
    .VAL_W(VAL_W), .MAX_VAL(MAX_VAL), .MAX_DIGITS(MAX_DIGITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .flush(flush),
    .num_valid(num_valid), .num_value(num_value), .num_err(num_err), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect the characters of the current token, judge it whole on a delimiter.
  logic [7:0]       tok [64];
  int               tok_len   = 0;
  logic             exp_valid = 1'b0;
  logic             exp_err   = 1'b0;
  logic [VAL_W-1:0] exp_value = '0;

  function automatic int tok_eval();
    int start = 0;
    int mag   = 0;
    int lim   = POS_LIM;
    bit neg   = 1'b0;
`ifdef UART_NUM_NEG_EN
    if (tok[0] == 8'h2D) begin
      neg = 1'b1; start = 1; lim = NEG_LIM;
    end
`endif
    if ((tok_len - start < 1) || (tok_len - start > MAX_DIGITS)) return BAD;
    for (int i = start; i < tok_len; i++) begin
      if ((tok[i] < 8'h30) || (tok[i] > 8'h39)) return BAD;
      mag = mag * 10 + int'(tok[i]) - 48;
    end
    if (mag > lim) return BAD;
    return neg ? -mag : mag;
  endfunction

  function automatic bit is_delim_b(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_len   <= 0;
      exp_valid <= 1'b0;
      exp_err   <= 1'b0;
      exp_value <= '0;
    end else begin
      exp_valid <= 1'b0;
      exp_err   <= 1'b0;
      if (flush) begin
        tok_len <= 0;
      end else if (rx_valid) begin
        if (is_delim_b(rx_data)) begin
          if (tok_len != 0) begin
            if (tok_eval() == BAD) begin
              exp_err <= 1'b1;
            end else begin
              exp_valid <= 1'b1;
              exp_value <= VAL_W'(tok_eval());
            end
          end
          tok_len <= 0;
        end else if (tok_len < 64) begin
          tok[tok_len] <= rx_data;
          tok_len      <= tok_len + 1;
        end
      end
    end
  end

  // Per-cycle compare and pulse log for the directed checks
  int obs_vals[$];
  int obs_errs = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("cyc num_valid", 32'(num_valid), 32'(exp_valid));
        check("cyc num_err", 32'(num_err), 32'(exp_err));
        check("cyc num_value", 32'(num_value), 32'(exp_value));
        check("cyc busy", 32'(busy), 32'(tok_len != 0));
        if (num_valid) obs_vals.push_back(int'(num_value));
        if (num_err) obs_errs++;
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] b, input bit f);
    @(posedge clk);
    #2;
    rx_valid = v;
    rx_data  = b;
    flush    = f;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    obs_vals.delete();
    obs_errs = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    check("reset num_valid", 32'(num_valid), 32'd0);
    check("reset num_err", 32'(num_err), 32'd0);
    check("reset num_value", 32'(num_value), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // "2 3 " and explicit one-cycle latency after a delimiter
    clr();
    send("2 3 ");
    settle();
    check("t1 count", obs_vals.size(), 32'd2);
    check("t1 first", obs_vals[0], 32'd2);
    check("t1 second", obs_vals[1], 32'd3);
    check("t1 errs", obs_errs, 32'd0);

    drive(1'b1, 8'h37, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    #3;
    check("lat pulse", 32'(num_valid), 32'd1);
    check("lat value", 32'(num_value), 32'd7);
    @(posedge clk);
    #3;
    check("lat drop", 32'(num_valid), 32'd0);

    // CR LF delimiters
    clr();
    drive(1'b1, 8'h31, 1'b0);
    drive(1'b1, 8'h32, 1'b0);
    drive(1'b1, 8'h0D, 1'b0);
    drive(1'b1, 8'h0A, 1'b0);
    send("255 ");
    settle();
    check("t2 first", obs_vals[0], 32'd12);
`ifdef UART_NUM_NEG_EN
    check("t2 count", obs_vals.size(), 32'd1);
    check("t2 errs", obs_errs, 32'd1);
`else
    check("t2 count", obs_vals.size(), 32'd2);
    check("t2 second", obs_vals[1], 32'd255);
    check("t2 errs", obs_errs, 32'd0);
`endif

    // overflow by value, then by digit count
    clr();
    send("256 000007 ");
    settle();
    check("t3 errs", obs_errs, 32'd2);
    check("t3 count", obs_vals.size(), 32'd0);
`ifdef UART_NUM_NEG_EN
    check("t3 held", 32'(num_value), 32'd12);
`else
    check("t3 held", 32'(num_value), 32'd255);
`endif

    // malformed token then a good one
    clr();
    send("4a5 7 ");
    settle();
    check("t4 errs", obs_errs, 32'd1);
    check("t4 count", obs_vals.size(), 32'd1);
    check("t4 value", obs_vals[0], 32'd7);

    // flush discards the partial token and the byte arriving with it
    clr();
    drive(1'b1, 8'h39, 1'b0);
    drive(1'b1, 8'h38, 1'b1);
    send("6 ");
    settle();
    check("t5 count", obs_vals.size(), 32'd1);
    check("t5 value", obs_vals[0], 32'd6);
    check("t5 errs", obs_errs, 32'd0);

    // asynchronous reset mid-token
    clr();
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    check("t6 busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 rst value", 32'(num_value), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    check("t6 rst pulses", 32'(num_valid | num_err), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(" ");
    settle();
    check("t6 no pulses", obs_vals.size() + obs_errs, 32'd0);

`ifdef UART_NUM_NEG_EN
    clr();
    send("-3 -128 128 - --1 -0 ");
    settle();
    check("neg count", obs_vals.size(), 32'd3);
    check("neg m3", obs_vals[0], 32'hFD);
    check("neg m128", obs_vals[1], 32'h80);
    check("neg m0", obs_vals[2], 32'h00);
    check("neg errs", obs_errs, 32'd3);
`else
    clr();
    send("-3 00255 ");
    settle();
    check("nosign errs", obs_errs, 32'd1);
    check("nosign value", obs_vals[0], 32'd255);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'(8'h30 + $urandom_range(0, 9));
      else if (r < 78) b = 8'h20;
      else if (r < 83) b = 8'h0D;
      else if (r < 87) b = 8'h0A;
      else if (r < 93) b = 8'h2D;
      else             b = 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 59) == 0));
    end
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_num_parser.md
Name: uart_num_parser

Overview:
- Receive-side ASCII decimal tokenizer between the UART receiver and the matrix input FSM.
- Consumes received bytes that carry whitespace-delimited decimal numbers, such as "2 3 1 2 3 ".
- Emits one binary value per completed token, or an error pulse for a malformed or out-of-range token.
- It is the hardware counterpart of the host-side number formatter that drives the PC UART line.

Parameters:
VAL_W, 8, width of num_value in bits
MAX_VAL, 255, largest accepted magnitude; must be < 2^VAL_W
MAX_DIGITS, 5, maximum digit characters per token, leading zeros included

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
rx_data  input  8  received byte
flush  input  1  synchronous abort: discard any partial token
num_valid  output  1  one-cycle pulse: num_value holds a new number
num_value  output  VAL_W  last parsed value; held until the next num_valid
num_err  output  1  one-cycle pulse: a token was rejected
busy  output  1  high while a token is partially received (state != S_IDLE)

Behaviour:
- Reset and clock: one clock; asynchronous active-low reset on rst_n. Reset clears all state: state=S_IDLE, acc=0, digit count=0, ovf=0, num_valid=0, num_err=0, num_value=0, busy=0. Reset mid-token drops the partial token; no pulse.
- Byte classes:
  - DIGIT: 0x30-0x39.
  - DELIM: 0x20 space, 0x0D CR, 0x0A LF.
  - OTHER: everything else.
- Processing rate: one byte per rx_valid cycle; back-to-back rx_valid on consecutive cycles is supported.
- State S_IDLE:
  - DIGIT -> S_NUM, acc=digit, cnt=1.
  - DELIM -> stay, no output; empty tokens are ignored.
  - OTHER -> S_SKIP.
- State S_NUM:
  - DIGIT -> acc=acc*10+digit, cnt+1.
    - Compute the product in VAL_W+4 bits.
    - If the result > MAX_VAL or cnt would exceed MAX_DIGITS: set ovf and freeze acc.
  - OTHER -> S_SKIP.
  - DELIM, ovf=0 -> num_value<=acc, num_valid=1 on the next cycle, state -> S_IDLE.
  - DELIM, ovf=1 -> num_err=1 on the next cycle, state -> S_IDLE.
- State S_SKIP:
  - DIGIT or OTHER -> stay.
  - DELIM -> num_err=1 on the next cycle, state -> S_IDLE.
- Latency and exclusivity: exactly 1 cycle from the delimiter's rx_valid to the num_valid/num_err pulse. num_valid and num_err are never high together.
- Cycles with rx_valid=0 change nothing; pulses drop after one cycle.
- flush:
  - Returns to S_IDLE and clears acc, cnt and ovf. No pulse is generated.
  - flush has priority over a simultaneous rx_valid byte; that byte is discarded.
  - num_value is retained.
- End of stream: a token with no trailing delimiter stays pending (busy=1) indefinitely until a delimiter, flush or reset arrives.

Optional Feature:
- Macro: UART_NUM_NEG_EN
- Enabled:
  - New state S_SIGN.
  - '-' (0x2D) in S_IDLE -> S_SIGN.
  - DIGIT in S_SIGN -> S_NUM with the neg flag set.
  - DELIM in S_SIGN -> num_err.
  - OTHER in S_SIGN, including a second '-' -> S_SKIP.
  - '-' inside S_NUM -> S_SKIP.
  - num_value is two's complement.
  - Positive limit: min(MAX_VAL, 2^(VAL_W-1)-1).
  - Negative magnitude limit: min(MAX_VAL, 2^(VAL_W-1)).
  - "-0" yields 0.
- Disabled: '-' is OTHER; num_value is unsigned, with limit MAX_VAL.

Test Plan:
- Bytes "2 3 " (0x32,0x20,0x33,0x20) -> num_valid pulses with values 2 then 3, each 1 cycle after its 0x20; num_err never asserted.
- "12\r\n255 " -> values 12 and 255; the LF after CR produces no output; busy is low after each delimiter.
- "256 " then "000007 " (default params) -> two num_err pulses (overflow, then 6 digits); num_value stays at its prior value; no num_valid.
- "4a5 " then "7 " -> num_err on the first space; num_valid with 7 on the second.
- "9" then flush asserted in the same cycle as rx_valid for "8", then "6 " -> single num_valid with 6; no num_err; reset asserted mid-token "3" -> all outputs 0 and no pulse after release.
- With UART_NUM_NEG_EN, VAL_W=8: "-3 " -> 8'hFD; "-128 " -> 8'h80; "128 " -> num_err; "- " -> num_err; "--1 " -> num_err.
